mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit and sequencer in the E stage of the pipelined MIPS core; owns the HI/LO registers.
- Takes the E-stage HILO operation, start pulse, RD1/RD2 operands and HI/LO read select, all from the ID/EX register outputs.
- Models fixed-latency mult/div with a cycle counter and drives busy so hazard control can stall D-stage HILO instructions.
- Serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5, cycles busy is high for mult/multu (must be ≥1).
- DIV_CYCLES, 10, cycles busy is high for div/divu (must be ≥1).

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that launches the mult/div given by HILOop.
- HILOop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others none.
- RD1  input  32  operand A (rs), already forwarded.
- RD2  input  32  operand B (rt), already forwarded.
- readHL  input  2  01 read HI, 10 read LO, else no read.
- busy  output  1  high while a mult/div is in flight.
- HL_rdata  output  32  HI/LO read data.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- States: IDLE, MULT, DIV. 2-bit state register plus 4-bit down-counter cnt. Result holding registers res_hi and res_lo.
- Reset (sync, highest priority): state=IDLE, cnt=0, busy=0, hi=0, lo=0, res_hi=0, res_lo=0. Reset mid-operation aborts it and HI/LO read 0 afterward.
- IDLE, start=1 with HILOop in 1..2:
  - Compute the 64-bit product at that edge into res_hi/res_lo. mult is signed×signed; multu is unsigned.
  - Go to MULT with cnt=MULT_CYCLES.
- IDLE, start=1 with HILOop in 3..4:
  - Compute quotient → res_lo, remainder → res_hi.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
  - Go to DIV with cnt=DIV_CYCLES.
  - Divisor 0: go to DIV as normal, but flag the result invalid so HI/LO stay unchanged at completion.
  - Signed 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- IDLE, start=1 with any other HILOop: ignored.
- busy is a registered output equal to (state≠IDLE).
  - Start sampled at edge T → busy=1 from edge T to edge T+N (N cycles), where N is the latency.
  - At edge T+N (cnt==1 in MULT/DIV): HI/LO ← res_hi/res_lo (unless divide-by-zero), state→IDLE, busy→0.
  - hi/lo show the new values in the same cycle busy falls.
- MULT/DIV: cnt decrements each edge. start is ignored (the pipeline never issues it while busy; the bench checks it is ignored).
- mthi/mtlo:
  - Act only when state=IDLE and start=0: HILOop 5 writes hi←RD1, HILOop 6 writes lo←RD1, visible next cycle.
  - Ignored while busy. Hazard control stalls them, so the drop is a defined fallback.
- start=1 with a mult/div op in the same cycle as HILOop 5/6 is impossible: one HILOop per cycle.
- HL_rdata is combinational: readHL==01 → hi, 10 → lo, else 0. It returns the pre-write value in the cycle of an mthi/mtlo or completion edge.
- Width rules: products use 64-bit sign- or zero-extended operands; no truncation beyond the HI/LO split. The counter never wraps (it reloads only from IDLE).
- Hazard contract, outside this block: the D-stage HILO instruction stalls while (start | busy).

Test Plan:
- mult, RD1=0xFFFFFFFD (−3), RD2=5, start pulse → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; readHL=10 → HL_rdata=0xFFFFFFF1.
- multu, RD1=0xFFFFFFFF, RD2=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. A second start during busy (div 9/3) is ignored: busy still falls at cycle 5 and HI/LO hold the multu result.
- div, RD1=0xFFFFFFF9 (−7), RD2=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 7/2 → LO=3, HI=1.
- mthi RD1=0x12345678, next cycle mtlo RD1=0x9ABCDEF0 → hi/lo take those values one cycle after each. divu RD1=7, RD2=0 → busy 10 cycles, HI/LO unchanged.
- div 100/7 started, reset asserted at busy cycle 4 → next cycle busy=0, hi=lo=0. No late writeback: HI/LO stay 0 for ≥12 cycles.
- Signed overflow: div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. readHL=00 → HL_rdata=0.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Pipeline-to-MDU handshake: E-stage HILO operation, operands and HI/LO read path.
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  HILOop;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [1:0]  readHL;
    logic        busy;
    logic [31:0] HL_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, HILOop, RD1, RD2, readHL,
        input  busy, HL_rdata, hi, lo
    );

    modport slave (
        input  start, HILOop, RD1, RD2, readHL,
        output busy, HL_rdata, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO; fixed-latency mult/div with busy for hazard stalls.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_ok;

    logic             is_mult;
    logic             is_div;
    logic [63:0]      op_a_ext;
    logic [63:0]      op_b_ext;
    logic [63:0]      product;
    logic             a_neg;
    logic             b_neg;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [31:0]      b_safe;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;
    logic [31:0]      quot;
    logic [31:0]      rem;

    // Result datapath evaluated on the launch cycle operands
    always_comb begin
        is_mult  = (bus.HILOop == OP_MULT) || (bus.HILOop == OP_MULTU);
        is_div   = (bus.HILOop == OP_DIV)  || (bus.HILOop == OP_DIVU);
        op_a_ext = (bus.HILOop == OP_MULT) ? {{32{bus.RD1[31]}}, bus.RD1} : {32'd0, bus.RD1};
        op_b_ext = (bus.HILOop == OP_MULT) ? {{32{bus.RD2[31]}}, bus.RD2} : {32'd0, bus.RD2};
        product  = op_a_ext * op_b_ext;

        // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000)
        a_neg  = (bus.HILOop == OP_DIV) && bus.RD1[31];
        b_neg  = (bus.HILOop == OP_DIV) && bus.RD2[31];
        a_mag  = a_neg ? (~bus.RD1 + 32'd1) : bus.RD1;
        b_mag  = b_neg ? (~bus.RD2 + 32'd1) : bus.RD2;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Sequencer, counter and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && is_mult) begin
                        res_hi <= product[63:32];
                        res_lo <= product[31:0];
                        res_ok <= 1'b1;
                        cnt    <= CNT_W'(MULT_CYCLES);
                        state  <= MULT;
                        busy_q <= 1'b1;
                    end else if (bus.start && is_div) begin
                        res_hi <= rem;
                        res_lo <= quot;
                        res_ok <= (bus.RD2 != 32'd0);
                        cnt    <= CNT_W'(DIV_CYCLES);
                        state  <= DIV;
                        busy_q <= 1'b1;
                    end else if (!bus.start) begin
                        if (bus.HILOop == OP_MTHI) hi_q <= bus.RD1;
                        if (bus.HILOop == OP_MTLO) lo_q <= bus.RD1;
                    end
                end
                MULT, DIV: begin
                    if (cnt == CNT_W'(1)) begin
                        if (res_ok) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Read port is combinational and shows pre-write values on update edges
    always_comb begin
        case (bus.readHL)
            2'b01:   bus.HL_rdata = hi_q;
            2'b10:   bus.HL_rdata = lo_q;
            default: bus.HL_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO and latency queued at issue, checked when busy falls.
module tb_mdu_ctrl;
    logic clk;
    logic reset;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    // Drive a start pulse at the current negedge and queue its expectation
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.cycles = ecyc;
        sb.push_back(e);
        bus.start  = 1'b1;
        bus.HILOop = op;
        bus.RD1    = a;
        bus.RD2    = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.HILOop = 4'd0;
    endtask

    // Count busy-high negedges (bounded); inputs are cleared after each edge
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
            bus.start  = 1'b0;
            bus.HILOop = 4'd0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b0; bus.HILOop = 4'd0; bus.RD1 = '0; bus.RD2 = '0; bus.readHL = 2'b01;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h want 0", bus.busy); end
        n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        n_checks++; if (bus.HL_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.HL_rdata); end
    endtask

    task automatic test_mult;
        int   cyc;
        exp_t e;
        issue(4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        wait_done(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want %0d", cyc, e.cycles); end
        n_checks++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL mult_hi got %h want %h", bus.hi, e.hi); end
        n_checks++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL mult_lo got %h want %h", bus.lo, e.lo); end
        bus.readHL = 2'b10; #1;
        n_checks++; if (bus.HL_rdata !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_read_lo got %h want fffffff1", bus.HL_rdata); end
        bus.readHL = 2'b01; #1;
        n_checks++; if (bus.HL_rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_read_hi got %h want ffffffff", bus.HL_rdata); end
    endtask

    task automatic test_multu_ignore_start;
        int   cyc;
        exp_t e;
        issue(4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
        bus.start = 1'b1; bus.HILOop = 4'd3; bus.RD1 = 32'd9; bus.RD2 = 32'd3;
        wait_done(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want %0d", cyc, e.cycles); end
        n_checks++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL multu_hi got %h want %h", bus.hi, e.hi); end
        n_checks++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL multu_lo got %h want %h", bus.lo, e.lo); end
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL multu_no_restart got %h want 0", bus.busy); end
    endtask

    task automatic test_div;
        int   cyc;
        exp_t e;
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        wait_done(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles) begin n_fail++; $display("FAIL div_busy_cycles got %0d want %0d", cyc, e.cycles); end
        n_checks++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL div_hi got %h want %h", bus.hi, e.hi); end
        n_checks++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL div_lo got %h want %h", bus.lo, e.lo); end
        issue(4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        wait_done(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles) begin n_fail++; $display("FAIL divu_busy_cycles got %0d want %0d", cyc, e.cycles); end
        n_checks++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL divu_hi got %h want %h", bus.hi, e.hi); end
        n_checks++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL divu_lo got %h want %h", bus.lo, e.lo); end
    endtask

    task automatic test_mthi_mtlo_divzero;
        int   cyc;
        exp_t e;
        bus.readHL = 2'b01;
        bus.HILOop = 4'd5; bus.RD1 = 32'h12345678; #1;
        n_checks++; if (bus.HL_rdata !== 32'd1) begin n_fail++; $display("FAIL mthi_prewrite_read got %h want 1", bus.HL_rdata); end
        @(negedge clk);
        n_checks++; if (bus.hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi got %h want 12345678", bus.hi); end
        n_checks++; if (bus.lo !== 32'd3) begin n_fail++; $display("FAIL mthi_lo_kept got %h want 3", bus.lo); end
        bus.HILOop = 4'd6; bus.RD1 = 32'h9ABCDEF0;
        @(negedge clk);
        bus.HILOop = 4'd0;
        n_checks++; if (bus.lo !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo got %h want 9abcdef0", bus.lo); end
        issue(4'd4, 32'd7, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10);
        bus.HILOop = 4'd5; bus.RD1 = 32'hDEADBEEF;
        wait_done(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles) begin n_fail++; $display("FAIL divzero_busy_cycles got %0d want %0d", cyc, e.cycles); end
        n_checks++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL divzero_hi got %h want %h", bus.hi, e.hi); end
        n_checks++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL divzero_lo got %h want %h", bus.lo, e.lo); end
    endtask

    task automatic test_reset_abort;
        exp_t e;
        issue(4'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        e = sb.pop_front();
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %h want 1", bus.busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %h want 0", bus.busy); end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
                n_fail++; $display("FAIL abort_no_writeback cyc %0d got %h/%h want 0/0 (expected before abort %h/%h)", i, bus.hi, bus.lo, e.hi, e.lo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow;
        int   cyc;
        exp_t e;
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
        wait_done(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== e.cycles) begin n_fail++; $display("FAIL ovf_busy_cycles got %0d want %0d", cyc, e.cycles); end
        n_checks++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL ovf_hi got %h want %h", bus.hi, e.hi); end
        n_checks++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL ovf_lo got %h want %h", bus.lo, e.lo); end
        bus.readHL = 2'b00; #1;
        n_checks++; if (bus.HL_rdata !== 32'd0) begin n_fail++; $display("FAIL ovf_read_none got %h want 0", bus.HL_rdata); end
    endtask

    task automatic test_back_to_back;
        int          cyc;
        exp_t        e;
        logic [31:0] a, b;
        logic [63:0] p;
        longint      sp;
        for (int i = 0; i < 6; i++) begin
            a = $urandom();
            b = $urandom();
            case (i % 3)
                0: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    p  = 64'(sp);
                    issue(4'd1, a, b, p[63:32], p[31:0], 5);
                end
                1: begin
                    p = {32'd0, a} * {32'd0, b};
                    issue(4'd2, a, b, p[63:32], p[31:0], 5);
                end
                default: begin
                    b = b | 32'd1;
                    issue(4'd4, a, b, a % b, a / b, 10);
                end
            endcase
            wait_done(cyc);
            e = sb.pop_front();
            n_checks++; if (cyc !== e.cycles) begin n_fail++; $display("FAIL b2b_cycles[%0d] got %0d want %0d", i, cyc, e.cycles); end
            n_checks++; if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin
                n_fail++; $display("FAIL b2b_result[%0d] a=%h b=%h got %h_%h want %h_%h", i, a, b, bus.hi, bus.lo, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mult();
        test_multu_ignore_start();
        test_div();
        test_mthi_mtlo_divzero();
        test_reset_abort();
        test_overflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
